// File: rtl/load_store_unit.sv
// Load/store unit between MEM stage and data memory: request FSM, lane extraction, alignment and timeout checks.
// Define LSU_STORE_FORWARD_EN to merge the last completed store into a following load to the same word.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [2:0]            req_type,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  stall,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  misaligned,
    output logic                  bus_error,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    output logic                  mem_read_req,
    input  logic                  mem_read_ready,
    input  logic [31:0]           mem_read_data,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic                  mem_write_req,
    output logic [31:0]           mem_write_data,
    output logic [2:0]            mem_write_type,
    input  logic                  mem_write_done
);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE} state_t;
    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            type_q, type_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  misaligned_q, misaligned_d;
    logic                  bus_error_q, bus_error_d;
    logic                  bad_req, rd_fin, wr_fin;
    logic [31:0]           load_word;

    // cnt_q == 0 marks the guard cycle, where the memory handshake is ignored
    assign rd_fin = (state_q == RD_WAIT) && (cnt_q != 8'd0) && mem_read_ready;
    assign wr_fin = (state_q == WR_WAIT) && (cnt_q != 8'd0) && mem_write_done;

    always_comb begin
        bad_req = 1'b1;
        case (req_type)
            3'b000, 3'b100: bad_req = 1'b0;
            3'b001, 3'b101: bad_req = req_addr[0];
            3'b010:         bad_req = |req_addr[1:0];
            default:        bad_req = 1'b1;
        endcase
    end

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] t,
                                            input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = w[{a[1], 4'b0000} +: 16];
        case (t[1:0])
            2'b00:   extract = t[2] ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   extract = t[2] ? {16'd0, h} : {{16{h[15]}}, h};
            default: extract = w;
        endcase
    endfunction

`ifdef LSU_STORE_FORWARD_EN
    logic                  fwd_vld_q, fwd_vld_d;
    logic [ADDR_WIDTH-3:0] fwd_addr_q, fwd_addr_d;
    logic [3:0]            fwd_be_q, fwd_be_d;
    logic [31:0]           fwd_data_q, fwd_data_d;
    logic [3:0]            st_be;
    logic [31:0]           st_lanes;

    always_comb begin
        st_be    = 4'b1111;
        st_lanes = wdata_q;
        case (type_q[1:0])
            2'b00: begin
                st_be    = 4'b0001 << addr_q[1:0];
                st_lanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                st_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                st_lanes = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
        fwd_vld_d  = fwd_vld_q;
        fwd_addr_d = fwd_addr_q;
        fwd_be_d   = fwd_be_q;
        fwd_data_d = fwd_data_q;
        if (wr_fin) begin
            fwd_vld_d  = 1'b1;
            fwd_addr_d = addr_q[ADDR_WIDTH-1:2];
            fwd_be_d   = st_be;
            fwd_data_d = st_lanes;
        end
        // Recorded store bytes win over a possibly stale memory word
        load_word = mem_read_data;
        if (fwd_vld_q && (fwd_addr_q == addr_q[ADDR_WIDTH-1:2])) begin
            for (int i = 0; i < 4; i++)
                if (fwd_be_q[i]) load_word[8*i +: 8] = fwd_data_q[8*i +: 8];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fwd_vld_q  <= 1'b0;
            fwd_addr_q <= '0;
            fwd_be_q   <= 4'd0;
            fwd_data_q <= 32'd0;
        end else begin
            fwd_vld_q  <= fwd_vld_d;
            fwd_addr_q <= fwd_addr_d;
            fwd_be_q   <= fwd_be_d;
            fwd_data_q <= fwd_data_d;
        end
    end
`else
    assign load_word = mem_read_data;
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        type_d       = type_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        cnt_d        = cnt_q;
        misaligned_d = 1'b0;
        bus_error_d  = 1'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                if (bad_req) begin
                    misaligned_d = 1'b1;
                end else begin
                    addr_d  = req_addr;
                    type_d  = req_type;
                    wdata_d = req_wdata;
                    state_d = req_write ? WR_REQ : RD_REQ;
                end
            end
            RD_REQ: begin
                cnt_d   = 8'd0;
                state_d = RD_WAIT;
            end
            WR_REQ: begin
                cnt_d   = 8'd0;
                state_d = WR_WAIT;
            end
            RD_WAIT, WR_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (rd_fin || wr_fin) begin
                    state_d = DONE;
                    if (rd_fin) rdata_d = extract(load_word, type_q, addr_q[1:0]);
                end else if (cnt_d == TIMEOUT_LIM) begin
                    bus_error_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            type_q       <= 3'd0;
            wdata_q      <= 32'd0;
            rdata_q      <= 32'd0;
            cnt_q        <= 8'd0;
            misaligned_q <= 1'b0;
            bus_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            type_q       <= type_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            cnt_q        <= cnt_d;
            misaligned_q <= misaligned_d;
            bus_error_q  <= bus_error_d;
        end
    end

    // Pulses are masked while reset is asserted so an aborted access emits nothing
    assign stall = ((state_q == IDLE) && req_valid) || (state_q == RD_REQ) ||
                   (state_q == RD_WAIT) || (state_q == WR_REQ) || (state_q == WR_WAIT);
    assign resp_valid     = (state_q == DONE) && !reset;
    assign mem_read_req   = (state_q == RD_REQ) && !reset;
    assign mem_write_req  = (state_q == WR_REQ) && !reset;
    assign misaligned     = misaligned_q && !reset;
    assign bus_error      = bus_error_q && !reset;
    assign resp_rdata     = rdata_q;
    assign mem_read_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign mem_write_addr = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_write_type = type_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset/DONE sequences, and random accesses vs a spec model.
module tb_load_store_unit;
    localparam int TO = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_write;
    logic [2:0]  req_type;
    logic [31:0] req_addr, req_wdata;
    logic        stall, resp_valid, misaligned, bus_error;
    logic [31:0] resp_rdata;
    logic [31:0] mem_read_addr, mem_write_addr, mem_write_data;
    logic        mem_read_req, mem_read_ready, mem_write_req, mem_write_done;
    logic [31:0] mem_read_data;
    logic [2:0]  mem_write_type;

    always #5 clock = ~clock;

    load_store_unit #(.TIMEOUT_CYCLES(TO), .ADDR_WIDTH(32)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_type(req_type),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .misaligned(misaligned), .bus_error(bus_error),
        .mem_read_addr(mem_read_addr), .mem_read_req(mem_read_req),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .mem_write_addr(mem_write_addr), .mem_write_req(mem_write_req),
        .mem_write_data(mem_write_data), .mem_write_type(mem_write_type),
        .mem_write_done(mem_write_done)
    );

    // rdy_at: memory handshake high from this wait cycle on (0 = never)
    typedef struct {
        logic        wr;
        logic [2:0]  t;
        logic [31:0] a, wd, mw;
        int          rdy_at;
    } req_t;

    // kind: 0 none, 1 resp_valid, 2 misaligned, 3 bus_error; cyc counted from the request cycle
    typedef struct {
        int          kind, cyc, stalls, rd_cnt, wr_cnt;
        logic [31:0] rd_addr, wr_addr, wr_data, rdata;
        logic [2:0]  wr_type;
    } obs_t;

    typedef struct {
        req_t        rq;
        int          kind;
        logic [31:0] rdata;
    } vec_t;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] model_rdata = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [2:0] t, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] mw, input int r,
                                input int k, input logic [31:0] rd);
        vec_t v;
        v.rq.wr = wr; v.rq.t = t; v.rq.a = a; v.rq.wd = wd; v.rq.mw = mw; v.rq.rdy_at = r;
        v.kind = k; v.rdata = rd;
        return v;
    endfunction

    // Reference: outcome of one access derived from the timing and extraction rules
    function automatic obs_t predict(input req_t q, input logic [31:0] prev);
        obs_t        e;
        int          ty, w;
        logic        legal;
        logic [31:0] v;
        e = '{default: 0};
        e.rdata = prev;
        ty = int'(q.t);
        legal = (ty == 0 || ty == 1 || ty == 2 || ty == 4 || ty == 5) &&
                !((ty % 4) == 1 && (q.a % 2) != 0) && !(ty == 2 && (q.a % 4) != 0);
        if (!legal) begin
            e.kind = 2; e.cyc = 1; e.stalls = 1;
            return e;
        end
        w = (q.rdy_at == 0) ? 1000 : ((q.rdy_at < 2) ? 2 : q.rdy_at);
        if (w > TO) begin e.kind = 3; e.cyc = TO + 2; end
        else        begin e.kind = 1; e.cyc = w + 2;  end
        e.stalls = e.cyc;
        if (q.wr) begin
            e.wr_cnt = 1; e.wr_addr = q.a; e.wr_data = q.wd; e.wr_type = q.t;
        end else begin
            e.rd_cnt = 1;
            e.rd_addr = q.a - (q.a % 4);
            if (e.kind == 1) begin
                if (ty % 4 == 0) begin
                    v = (q.mw >> (8 * (q.a % 4))) & 32'hFF;
                    if (ty == 0 && v >= 128) v = v + 32'hFFFFFF00;
                end else if (ty % 4 == 1) begin
                    v = (q.mw >> (16 * ((q.a / 2) % 2))) & 32'hFFFF;
                    if (ty == 1 && v >= 32768) v = v + 32'hFFFF0000;
                end else begin
                    v = q.mw;
                end
                e.rdata = v;
            end
        end
        return e;
    endfunction

    task automatic run(input req_t q, output obs_t o);
        int   s = -1;
        logic rdy;
        o = '{default: 0};
        o.cyc = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            req_valid = (i == 0); req_write = q.wr; req_type = q.t;
            req_addr = q.a; req_wdata = q.wd; mem_read_data = q.mw;
            rdy = (s >= 0) && (q.rdy_at > 0) && (i - s >= q.rdy_at);
            mem_read_ready = rdy && !q.wr;
            mem_write_done = rdy && q.wr;
            #1;
            if (stall) o.stalls++;
            if (mem_read_req) begin o.rd_cnt++; o.rd_addr = mem_read_addr; s = i; end
            if (mem_write_req) begin
                o.wr_cnt++; o.wr_addr = mem_write_addr; o.wr_data = mem_write_data;
                o.wr_type = mem_write_type; s = i;
            end
            if (resp_valid || misaligned || bus_error) begin
                o.kind = resp_valid ? 1 : (misaligned ? 2 : 3);
                o.cyc = i;
                o.rdata = resp_rdata;
                break;
            end
        end
        req_valid = 1'b0; mem_read_ready = 1'b0; mem_write_done = 1'b0;
    endtask

    task automatic compare(input string tag, input obs_t o, input obs_t e);
        chk({tag, " kind"}, o.kind, e.kind);
        chk({tag, " cycle"}, o.cyc, e.cyc);
        chk({tag, " stalls"}, o.stalls, e.stalls);
        chk({tag, " rd_strobes"}, o.rd_cnt, e.rd_cnt);
        chk({tag, " wr_strobes"}, o.wr_cnt, e.wr_cnt);
        if (e.rd_cnt == 1) chk({tag, " rd_addr"}, o.rd_addr, e.rd_addr);
        if (e.wr_cnt == 1) begin
            chk({tag, " wr_addr"}, o.wr_addr, e.wr_addr);
            chk({tag, " wr_data"}, o.wr_data, e.wr_data);
            chk({tag, " wr_type"}, 32'(o.wr_type), 32'(e.wr_type));
        end
        chk({tag, " rdata"}, o.rdata, e.rdata);
    endtask

    task automatic do_access(input string tag, input req_t q, output obs_t o);
        obs_t e;
        e = predict(q, model_rdata);
        run(q, o);
        compare(tag, o, e);
        model_rdata = e.rdata;
    endtask

    initial begin
        vec_t  vecs[15];
        obs_t  o;
        req_t  q;
        int    r;
        logic  pulse;

        vecs[0]  = mk(0, 3'b010, 32'h10, 0, 32'hDEADBEEF, 2, 1, 32'hDEADBEEF);
        vecs[1]  = mk(0, 3'b000, 32'h13, 0, 32'h80FF0102, 1, 1, 32'hFFFFFF80);
        vecs[2]  = mk(0, 3'b100, 32'h13, 0, 32'h80FF0102, 3, 1, 32'h00000080);
        vecs[3]  = mk(0, 3'b101, 32'h12, 0, 32'h80FF0102, 2, 1, 32'h000080FF);
        vecs[4]  = mk(0, 3'b001, 32'h12, 0, 32'h80FF0102, 2, 1, 32'hFFFF80FF);
        vecs[5]  = mk(0, 3'b000, 32'h11, 0, 32'h80FF0102, 2, 1, 32'h00000001);
        vecs[6]  = mk(1, 3'b001, 32'h21, 32'h1234, 0, 1, 2, 32'h00000001);
        vecs[7]  = mk(0, 3'b010, 32'h22, 0, 32'h55555555, 1, 2, 32'h00000001);
        vecs[8]  = mk(1, 3'b000, 32'h05, 32'hAA, 0, 1, 1, 32'h00000001);
        vecs[9]  = mk(0, 3'b011, 32'h00, 0, 32'h55555555, 1, 2, 32'h00000001);
        vecs[10] = mk(0, 3'b010, 32'h40, 0, 32'h11111111, 0, 3, 32'h00000001);
        vecs[11] = mk(0, 3'b111, 32'h04, 0, 32'h11111111, 1, 2, 32'h00000001);
        vecs[12] = mk(1, 3'b010, 32'h08, 32'hCAFEF00D, 0, 4, 1, 32'h00000001);
        vecs[13] = mk(0, 3'b001, 32'h16, 0, 32'h7FFF8000, 2, 1, 32'h00007FFF);
        vecs[14] = mk(0, 3'b010, 32'h44, 0, 32'h12345678, TO, 1, 32'h12345678);

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_type = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; mem_read_ready = 1'b0;
        mem_read_data = 32'd0; mem_write_done = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("reset pulses", {26'd0, stall, resp_valid, misaligned, bus_error, mem_read_req, mem_write_req}, 32'd0);
        chk("reset rdata", resp_rdata, 32'd0);
        chk("reset mem_addrs", mem_read_addr | mem_write_addr, 32'd0);

        foreach (vecs[i]) begin
            do_access($sformatf("vec%0d", i), vecs[i].rq, o);
            chk($sformatf("vec%0d table_kind", i), o.kind, vecs[i].kind);
            chk($sformatf("vec%0d table_rdata", i), o.rdata, vecs[i].rdata);
        end

        // Request raised during DONE must wait for the following IDLE cycle
        q = mk(0, 3'b010, 32'h30, 0, 32'hA5A5A5A5, 2, 1, 0).rq;
        do_access("done_first", q, o);
        req_valid = 1'b1; req_write = 1'b0; req_type = 3'b010; req_addr = 32'h34;
        #1;
        chk("done stall", 32'(stall), 32'd0);
        q = mk(0, 3'b010, 32'h34, 0, 32'h5A5A5A5A, 2, 1, 0).rq;
        do_access("done_next", q, o);

        // Reset while waiting on a read aborts it with no pulse
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b0; req_type = 3'b010; req_addr = 32'h50;
        mem_read_ready = 1'b0; mem_read_data = 32'h77777777;
        @(negedge clock); req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock); reset = 1'b1; mem_read_ready = 1'b1;
        #1;
        chk("rst_wait pulses", {29'd0, resp_valid, bus_error, misaligned}, 32'd0);
        @(negedge clock); reset = 1'b0; mem_read_ready = 1'b0;
        #1;
        chk("rst_wait outs", {26'd0, stall, resp_valid, misaligned, bus_error, mem_read_req, mem_write_req}, 32'd0);
        chk("rst_wait rdata", resp_rdata, 32'd0);
        pulse = 1'b0;
        repeat (4) begin
            @(negedge clock); #1;
            pulse = pulse | resp_valid | bus_error | stall | mem_read_req;
        end
        chk("rst_wait quiet", 32'(pulse), 32'd0);
        model_rdata = 32'd0;

        for (int n = 0; n < 40; n++) begin
            q.wr = 1'($urandom_range(0, 1));
            q.t  = 3'($urandom_range(0, 7));
            if (q.wr && (q.t == 3'd4 || q.t == 3'd5)) q.t = q.t - 3'd4;
            q.a  = $urandom_range(0, 63);
            q.wd = $urandom;
            q.mw = $urandom;
            r = $urandom_range(0, 9);
            q.rdy_at = (r == 0) ? 0 : ((r == 1) ? TO + 1 : r - 1);
            do_access($sformatf("rand%0d", n), q, o);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
